gray_counter: RTL and testbench
===============================

# gray_counter

Registered Gray-code counter that generates the Gray-coded values consumed by the `gray2bin` stage, for example as an async-FIFO pointer source or a Gray-sequenced address generator. It keeps a binary count internally and registers both the Gray and binary forms, so at most one bit of `gray_out` changes per increment. A synchronous load accepts a Gray-coded value, which makes the block's output and load paths symmetric with the downstream converter.

## Interface
- `DATA_WIDTH`, default 8, counter width in bits; legal range is 2 or greater.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `en`  in  1  advance the count by one step this cycle.
- `load`  in  1  load `load_gray` this cycle.
- `load_gray`  in  DATA_WIDTH  Gray-coded load value.
- `dir`  in  1  count direction: 1 = up, 0 = down. This port exists only when `GRAY_COUNTER_DOWN_EN` is defined.
- `gray_out`  out  DATA_WIDTH  registered Gray count.
- `bin_out`  out  DATA_WIDTH  registered binary equivalent of `gray_out`.
- `wrap`  out  1  registered one-cycle pulse when the count wraps.

## Operation
- Priority on each rising edge of `clk`: `rst`, then `load`, then `en`, then hold.
- Reset: `bin_out`, `gray_out` and `wrap` are all cleared to 0.
- Load: `bin_out` takes the binary conversion of `load_gray`, and `gray_out` takes `load_gray` unchanged. `wrap` is 0. `en` is ignored in that cycle.
- Count up: `bin_next = bin_out + 1`, computed modulo 2^DATA_WIDTH, so there is no saturation.
- Count down (macro defined only): `bin_next = bin_out - 1`, also modulo 2^DATA_WIDTH.
- Gray output: `gray_out <= bin_next ^ (bin_next >> 1)`. It is always derived from the registered binary value and is never incremented as Gray directly.
- Wrap, up direction: `wrap` is 1 when `en` is high and `bin_out` is all-ones, so the count goes to 0.
- Wrap, down direction: `wrap` is 1 when `en` is high, `dir` is 0 and `bin_out` is 0, so the count goes to all-ones.
- `wrap` is 0 in every other cycle.
- Hold: when `en` and `load` are both low, all outputs keep their values and `wrap` is 0.
- Reset mid-count: the count restarts from 0 on the next edge, with no residual `wrap` pulse.
- Invariant: `bin_out == gray2bin(gray_out)` holds in every cycle after the first clock edge following reset.
- Invariant: between consecutive `en` cycles with no load, `gray_out` changes by exactly 1 bit (Hamming distance 1), including across the wrap.

## Timing
- All outputs are registered and update on the rising edge of `clk`. There is no combinational input-to-output path.
- Latency: `en`, `load` or `rst` sampled at edge N is visible on the outputs after edge N.
- `wrap` is asserted in the same cycle as the wrapped value appears on `gray_out`/`bin_out`.
- Throughput: one step per cycle with `en` held high continuously.
- The `load_gray` to binary conversion is a DATA_WIDTH-deep XOR prefix chain, inside a single register-to-register cycle.

## Configuration
- Macro `GRAY_COUNTER_DOWN_EN`.
- Defined:
  - the `dir` port exists and controls direction;
  - down-count and underflow `wrap` behave as described in Operation;
  - changing `dir` between cycles is legal and takes effect at the next enabled edge.
- Undefined:
  - no `dir` port;
  - up-count only;
  - the subtract and direction logic is not synthesised.

## Structure
- Shared header `gray_defs.vh` holds:
  - the default width constant `GRAY_DEFAULT_WIDTH = 8`;
  - the all-ones and zero terminal-count constant expressions used for wrap detection.
- Natural sub-module: `bin2gray`, a combinational, parameterised `DATA_WIDTH` converter (`binary_in` to `gray_out`), used on the `bin_next` path.
- The load path reuses the existing `gray2bin` instance for `load_gray` to binary conversion.

## Test plan
- Reset: assert `rst` for 2 cycles with `en` = 1 → `gray_out` = 0x00, `bin_out` = 0x00, `wrap` = 0.
- Load then count: `load_gray` = 8'b01010101 with `load` = 1 → `bin_out` = 0x66, `gray_out` = 0x55. Next cycle with `en` = 1 → `bin_out` = 0x67, `gray_out` = 8'b01010100.
- Full sweep: 256 cycles of `en` from reset → each step has `gray_out` Hamming distance 1 and `bin_out` == gray2bin(`gray_out`). The step from `bin_out` 0xFF (`gray_out` 0x80) to 0x00 pulses `wrap` for exactly one cycle.
- Priority: `load` = 1 and `en` = 1 with `load_gray` = 0xC0 → `bin_out` = 0x80, not 0x81, and `wrap` = 0. `rst` = 1 with `load` = 1 → all outputs 0.
- Hold: `en` = 0 for 5 cycles at `bin_out` = 0x10 → outputs unchanged and `wrap` = 0 throughout.
- With `GRAY_COUNTER_DOWN_EN`: from reset, `en` = 1, `dir` = 0 → `bin_out` = 0xFF, `gray_out` = 0x80, `wrap` = 1. Next cycle → `bin_out` = 0xFE, `gray_out` = 0x81, `wrap` = 0.

Source files
------------

// File: rtl/gray_counter_pkg.sv
// Shared constants and the per-edge operation select for the Gray-code counter.
// The optional down-count feature is enabled with the GRAY_COUNTER_DOWN_EN macro.
package gray_counter_pkg;

   localparam int GRAY_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_LOAD  = 2'd1,
      OP_COUNT = 2'd2
   } op_e;

endpackage

// File: rtl/gray_counter_conv.sv
// Combinational binary<->Gray converters shared by the counter's step path and load path.
module bin2gray
   import gray_counter_pkg::*;
#(
   parameter int DATA_WIDTH = GRAY_DEFAULT_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] binary_in,
   output logic [DATA_WIDTH-1:0] gray_out
);

   assign gray_out = binary_in ^ (binary_in >> 1);

endmodule

module gray2bin
   import gray_counter_pkg::*;
#(
   parameter int DATA_WIDTH = GRAY_DEFAULT_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] gray_in,
   output logic [DATA_WIDTH-1:0] binary_out
);

   logic                  acc;
   logic [DATA_WIDTH-1:0] bin_v;

   // XOR prefix from the MSB down: each binary bit is the parity of all Gray bits above and at it.
   always_comb begin
      acc   = 1'b0;
      bin_v = '0;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         acc      = acc ^ gray_in[i];
         bin_v[i] = acc;
      end
   end

   assign binary_out = bin_v;

endmodule

// File: rtl/gray_counter.sv
// Registered Gray-code counter with Gray-coded synchronous load and wrap pulse.
// Define GRAY_COUNTER_DOWN_EN to add the dir port and down-count/underflow wrap.
module gray_counter
   import gray_counter_pkg::*;
#(
   parameter int DATA_WIDTH = GRAY_DEFAULT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_gray,
`ifdef GRAY_COUNTER_DOWN_EN
   input  logic                  dir,
`endif
   output logic [DATA_WIDTH-1:0] gray_out,
   output logic [DATA_WIDTH-1:0] bin_out,
   output logic                  wrap
);

   localparam logic [DATA_WIDTH-1:0] TC_ONES = '1;
   localparam logic [DATA_WIDTH-1:0] TC_ZERO = '0;
   localparam logic [DATA_WIDTH-1:0] ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] bin_q,  bin_d;
   logic [DATA_WIDTH-1:0] gray_q, gray_d;
   logic                  wrap_q, wrap_d;

   logic [DATA_WIDTH-1:0] bin_step;
   logic [DATA_WIDTH-1:0] gray_step;
   logic [DATA_WIDTH-1:0] load_bin;
   logic                  wrap_hit;
   op_e                   op;

`ifdef GRAY_COUNTER_DOWN_EN
   assign bin_step = dir ? (bin_q + ONE) : (bin_q - ONE);
   assign wrap_hit = dir ? (bin_q == TC_ONES) : (bin_q == TC_ZERO);
`else
   assign bin_step = bin_q + ONE;
   assign wrap_hit = (bin_q == TC_ONES);
`endif

   // Gray is always re-derived from the binary step so only one bit can flip.
   bin2gray #(.DATA_WIDTH(DATA_WIDTH)) u_bin2gray (
      .binary_in (bin_step),
      .gray_out  (gray_step)
   );

   gray2bin #(.DATA_WIDTH(DATA_WIDTH)) u_gray2bin (
      .gray_in    (load_gray),
      .binary_out (load_bin)
   );

   always_comb begin
      op     = OP_HOLD;
      bin_d  = bin_q;
      gray_d = gray_q;
      wrap_d = 1'b0;
      if (load) begin
         op = OP_LOAD;
      end else if (en) begin
         op = OP_COUNT;
      end
      unique case (op)
         OP_LOAD: begin
            bin_d  = load_bin;
            gray_d = load_gray;
         end
         OP_COUNT: begin
            bin_d  = bin_step;
            gray_d = gray_step;
            wrap_d = wrap_hit;
         end
         default: begin
            bin_d  = bin_q;
            gray_d = gray_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         gray_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign bin_out  = bin_q;
   assign gray_out = gray_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter (8-bit); down-count tests run when
// GRAY_COUNTER_DOWN_EN is defined.
module tb_gray_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       load;
   logic [7:0] load_gray;
`ifdef GRAY_COUNTER_DOWN_EN
   logic       dir;
`endif
   logic [7:0] gray_out;
   logic [7:0] bin_out;
   logic       wrap;

   int checks   = 0;
   int failures = 0;

   gray_counter #(.DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .load      (load),
      .load_gray (load_gray),
`ifdef GRAY_COUNTER_DOWN_EN
      .dir       (dir),
`endif
      .gray_out  (gray_out),
      .bin_out   (bin_out),
      .wrap      (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; load = 1'b0; load_gray = 8'h00;
      tick();
      tick();
      checks++;
      if (gray_out !== 8'h00) begin
         failures++; $display("FAIL reset_gray got=%h exp=00", gray_out);
      end
      checks++;
      if (bin_out !== 8'h00) begin
         failures++; $display("FAIL reset_bin got=%h exp=00", bin_out);
      end
      checks++;
      if (wrap !== 1'b0) begin
         failures++; $display("FAIL reset_wrap got=%b exp=0", wrap);
      end
      rst = 1'b0; en = 1'b0;
   endtask

   task automatic test_load_count();
      load = 1'b1; load_gray = 8'b0101_0101;
      tick();
      checks++;
      if (bin_out !== 8'h66 || gray_out !== 8'h55 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL load55 got bin=%h gray=%h wrap=%b exp bin=66 gray=55 wrap=0", bin_out, gray_out, wrap);
      end
      load = 1'b0; en = 1'b1;
      tick();
      checks++;
      if (bin_out !== 8'h67 || gray_out !== 8'h54 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL load_then_count got bin=%h gray=%h wrap=%b exp bin=67 gray=54 wrap=0", bin_out, gray_out, wrap);
      end
      en = 1'b0;
   endtask

   task automatic test_sweep();
      logic [7:0] exp_bin;
      logic [7:0] prev_gray;
      int         wrap_seen;
      rst = 1'b1; en = 1'b0; load = 1'b0;
      tick();
      rst = 1'b0; en = 1'b1;
      exp_bin   = 8'h00;
      prev_gray = 8'h00;
      wrap_seen = 0;
      for (int k = 1; k <= 256; k++) begin
         tick();
         exp_bin = exp_bin + 8'h01;
         checks++;
         if (bin_out !== exp_bin || gray_out !== (exp_bin ^ (exp_bin >> 1))) begin
            failures++;
            $display("FAIL sweep_value step=%0d got bin=%h gray=%h exp bin=%h gray=%h",
                     k, bin_out, gray_out, exp_bin, exp_bin ^ (exp_bin >> 1));
         end
         checks++;
         if ($countones(gray_out ^ prev_gray) != 1) begin
            failures++;
            $display("FAIL sweep_hamming step=%0d got prev=%h now=%h exp distance 1", k, prev_gray, gray_out);
         end
         checks++;
         if (wrap !== (k == 256)) begin
            failures++;
            $display("FAIL sweep_wrap step=%0d got=%b exp=%b", k, wrap, (k == 256));
         end
         if (wrap === 1'b1) wrap_seen++;
         prev_gray = gray_out;
      end
      tick();
      checks++;
      if (wrap !== 1'b0 || bin_out !== 8'h01 || wrap_seen != 1) begin
         failures++;
         $display("FAIL sweep_after_wrap got wrap=%b bin=%h pulses=%0d exp wrap=0 bin=01 pulses=1", wrap, bin_out, wrap_seen);
      end
      en = 1'b0;
   endtask

   task automatic test_priority();
      load = 1'b1; en = 1'b1; load_gray = 8'hC0;
      tick();
      checks++;
      if (bin_out !== 8'h80 || gray_out !== 8'hC0 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL prio_load_en got bin=%h gray=%h wrap=%b exp bin=80 gray=c0 wrap=0", bin_out, gray_out, wrap);
      end
      load_gray = 8'h80;
      tick();
      // Load of the all-ones value must not be treated as a wrap even with en high.
      tick();
      checks++;
      if (bin_out !== 8'hFF || gray_out !== 8'h80 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL prio_load_at_ones got bin=%h gray=%h wrap=%b exp bin=ff gray=80 wrap=0", bin_out, gray_out, wrap);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (bin_out !== 8'h00 || gray_out !== 8'h00 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL prio_rst_load got bin=%h gray=%h wrap=%b exp all 0", bin_out, gray_out, wrap);
      end
      rst = 1'b0; load = 1'b0; en = 1'b0;
   endtask

   task automatic test_hold();
      load = 1'b1; load_gray = 8'h18;
      tick();
      load = 1'b0; en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (bin_out !== 8'h10 || gray_out !== 8'h18 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL hold cycle=%0d got bin=%h gray=%h wrap=%b exp bin=10 gray=18 wrap=0", i, bin_out, gray_out, wrap);
         end
      end
   endtask

   task automatic test_back_to_back();
      load = 1'b1; load_gray = 8'h80;
      tick();
      load = 1'b0; en = 1'b1; rst = 1'b1;
      tick();
      checks++;
      if (bin_out !== 8'h00 || gray_out !== 8'h00 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_count got bin=%h gray=%h wrap=%b exp all 0", bin_out, gray_out, wrap);
      end
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (bin_out !== 8'h02 || gray_out !== 8'h03 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL restart_count got bin=%h gray=%h wrap=%b exp bin=02 gray=03 wrap=0", bin_out, gray_out, wrap);
      end
      en = 1'b0;
   endtask

`ifdef GRAY_COUNTER_DOWN_EN
   task automatic test_down();
      rst = 1'b1; en = 1'b0; load = 1'b0; dir = 1'b1;
      tick();
      rst = 1'b0; en = 1'b1; dir = 1'b0;
      tick();
      checks++;
      if (bin_out !== 8'hFF || gray_out !== 8'h80 || wrap !== 1'b1) begin
         failures++;
         $display("FAIL down_underflow got bin=%h gray=%h wrap=%b exp bin=ff gray=80 wrap=1", bin_out, gray_out, wrap);
      end
      tick();
      checks++;
      if (bin_out !== 8'hFE || gray_out !== 8'h81 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL down_step got bin=%h gray=%h wrap=%b exp bin=fe gray=81 wrap=0", bin_out, gray_out, wrap);
      end
      dir = 1'b1;
      tick();
      checks++;
      if (bin_out !== 8'hFF || gray_out !== 8'h80 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL dir_change got bin=%h gray=%h wrap=%b exp bin=ff gray=80 wrap=0", bin_out, gray_out, wrap);
      end
      en = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; load_gray = 8'h00;
`ifdef GRAY_COUNTER_DOWN_EN
      dir = 1'b1;
`endif
      test_reset();
      test_load_count();
      test_sweep();
      test_priority();
      test_hold();
      test_back_to_back();
`ifdef GRAY_COUNTER_DOWN_EN
      test_down();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
